bcd_conv_scheduler: RTL and testbench
=====================================

// Module: bcd_conv_scheduler
// PURPOSE
//   Shares one binary-to-BCD converter among NCH requesters (ch0 = sec, ch1 = min, ch2 = hour).
//   It arbitrates requests round-robin, drives the converter input and waits the converter latency.
//   It then captures the result into a per-channel BCD holding register.
//   Sits between the timekeeping counters and the 7-segment display mux.
// PARAMETERS
//   NCH       3   number of requesting channels (2..8)
//   CONV_LAT  2   converter latency in cycles, from conv_bin change to valid conv_bcd (>=1)
//   MAX_VAL   99  largest legal binary value; larger inputs are clamped
// PORTS
//   clk        in   1      clock
//   rst_n      in   1      synchronous, active-low reset
//   req        in   NCH    level request per channel; held until acked
//   bin_in     in   8*NCH  binary value per channel; ch k = bin_in[8k+7:8k]
//   ack        out  NCH    1-cycle pulse: request accepted, bin_in sampled
//   conv_bin   out  8      binary value driven to the shared converter
//   conv_bcd   in   8      packed BCD {tens,units} returned by the converter
//   bcd_out    out  8*NCH  last converted BCD per channel
//   bcd_done   out  NCH    1-cycle pulse when bcd_out[ch] is updated
//   range_err  out  NCH    ch's last accepted value was > MAX_VAL
//   busy       out  1      high while not in IDLE
// BEHAVIOUR
//   Reset values (all outputs, state and pointer):
//     - ack, conv_bin, bcd_out, bcd_done, range_err: 0
//     - busy: 0; state: IDLE; RR pointer: ch0 highest priority
//   FSM: IDLE -> WAIT -> CAPTURE -> IDLE
//   IDLE (cycle G), when req != 0:
//     - grant g = first requesting ch at or after the RR pointer, wrapping; ptr <= g+1 mod NCH
//     - sample bin_in[g]; value > MAX_VAL -> drive MAX_VAL, set range_err[g], else clear range_err[g]
//     - registered into conv_bin; ack[g] pulses in cycle I = G+1; go to WAIT with cnt = CONV_LAT
//   WAIT:
//     - conv_bin held stable; cnt decrements each cycle
//     - when cnt reaches 0 (cycle I+CONV_LAT) the converter output is valid -> CAPTURE
//   CAPTURE:
//     - bcd_out[g] <= conv_bcd at end of cycle I+CONV_LAT
//     - bcd_done[g] pulses in cycle I+CONV_LAT+1 and the state returns to IDLE
//     - a new grant may be decided in that same IDLE cycle
//   Latency: req seen at G -> bcd_done at G+CONV_LAT+2; throughput 1 conversion per CONV_LAT+2 cycles.
//   busy = (state != IDLE).
//   Requests:
//     - req arriving or held during WAIT/CAPTURE waits; no ack outside IDLE
//     - req dropped before ack: never served
//     - req deasserted or bin_in changed after ack: no effect on the conversion in flight
//     - g re-requesting while in flight: queued, served in normal RR order
//   Other bcd_out channels hold their values; only the granted channel updates.
//   conv_bin width is 8; bits above log2(MAX_VAL) are zero after clamping.
//   Reset mid-operation: in-flight conversion abandoned, no bcd_done, all outputs return to reset values.
// TESTING
//   1. Reset, req=0 for 10 cycles -> busy=0, ack=0, bcd_done=0, bcd_out all 0.
//   2. req[0] with bin=45 at G -> ack[0] at G+1, conv_bin=45, bcd_out[0]=0x45 and bcd_done[0] at G+4.
//   3. req=3'b111 together, bins 59/59/23 -> acks in order ch0, ch1, ch2, each 4 cycles apart.
//      bcd_out = 0x59/0x59/0x23.
//   4. ch0 and ch2 requesting continuously -> grants alternate 0, 2, 0, 2; ch1 never acked.
//   5. req[2] with bin=120 -> bcd_out[2]=0x99, range_err[2]=1.
//      A later bin=7 -> bcd_out[2]=0x07, range_err[2]=0.
//   6. rst_n low for 1 cycle in WAIT of ch1 (bin=30) -> no bcd_done[1], bcd_out[1]=0.
//      The next req[1] is acked fresh.

Source files
------------

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one binary-to-BCD converter among NCH channels.
// Grants in IDLE, waits CONV_LAT cycles for the converter, then captures per-channel BCD.
module bcd_conv_scheduler #(
    parameter int unsigned NCH      = 3,
    parameter int unsigned CONV_LAT = 2,
    parameter int unsigned MAX_VAL  = 99
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     req,
    input  logic [8*NCH-1:0]   bin_in,
    output logic [NCH-1:0]     ack,
    output logic [7:0]         conv_bin,
    input  logic [7:0]         conv_bcd,
    output logic [8*NCH-1:0]   bcd_out,
    output logic [NCH-1:0]     bcd_done,
    output logic [NCH-1:0]     range_err,
    output logic               busy
);

    localparam int unsigned PW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW    = $clog2(CONV_LAT + 1);
    localparam logic [7:0]  MAX_B = 8'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cur_ch;
    logic [CW-1:0] cnt;
    logic [7:0]    bcd_arr [NCH];
    logic [7:0]    bin_arr [NCH];

    logic [PW-1:0] grant_idx;
    logic          grant_vld;
    logic [PW:0]   cand;
    logic [7:0]    sel_bin;

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign bin_arr[k]          = bin_in[8*k +: 8];
        assign bcd_out[8*k +: 8]   = bcd_arr[k];
    end

    // First requester at or after ptr, wrapping modulo NCH.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NCH)) begin
                cand = cand - (PW+1)'(NCH);
            end
            if (!grant_vld && req[cand[PW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PW-1:0];
            end
        end
    end

    assign sel_bin = bin_arr[grant_idx];
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cur_ch    <= '0;
            cnt       <= '0;
            ack       <= '0;
            conv_bin  <= '0;
            bcd_done  <= '0;
            range_err <= '0;
            for (int k = 0; k < NCH; k++) begin
                bcd_arr[k] <= '0;
            end
        end else begin
            ack      <= '0;
            bcd_done <= '0;
            unique case (state)
                IDLE: begin
                    if (grant_vld) begin
                        ack[grant_idx] <= 1'b1;
                        cur_ch         <= grant_idx;
                        ptr            <= (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + PW'(1);
                        if (sel_bin > MAX_B) begin
                            conv_bin             <= MAX_B;
                            range_err[grant_idx] <= 1'b1;
                        end else begin
                            conv_bin             <= sel_bin;
                            range_err[grant_idx] <= 1'b0;
                        end
                        cnt   <= CW'(CONV_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // cnt hits 0 in the cycle the converter output becomes valid
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    bcd_arr[cur_ch]  <= conv_bcd;
                    bcd_done[cur_ch] <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: directed sequences, a vector table and a randomized
// run against a transaction-level model; the converter is a CONV_LAT-deep pipeline.
module tb_bcd_conv_scheduler;

    localparam int NCH = 3;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   req = '0;
    logic [8*NCH-1:0] bin_in = '0;
    logic [NCH-1:0]   ack;
    logic [7:0]       conv_bin;
    logic [7:0]       conv_bcd;
    logic [8*NCH-1:0] bcd_out;
    logic [NCH-1:0]   bcd_done;
    logic [NCH-1:0]   range_err;
    logic             busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] mdl_bcd [NCH];
    logic [7:0] pipe [LAT];

    bcd_conv_scheduler #(.NCH(NCH), .CONV_LAT(LAT), .MAX_VAL(99)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bin_in    (bin_in),
        .ack       (ack),
        .conv_bin  (conv_bin),
        .conv_bcd  (conv_bcd),
        .bcd_out   (bcd_out),
        .bcd_done  (bcd_done),
        .range_err (range_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd_of(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    always_ff @(posedge clk) begin
        pipe[0] <= bcd_of(int'(conv_bin));
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign conv_bcd = pipe[LAT-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        req   = '0;
        repeat (n) tick();
        rst_n = 1'b1;
        for (int k = 0; k < NCH; k++) mdl_bcd[k] = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    function automatic logic [23:0] mdl_pack();
        return {mdl_bcd[2], mdl_bcd[1], mdl_bcd[0]};
    endfunction

    // One isolated request; checks ack latency, clamping, done latency and holding of others.
    task automatic convert_one(input int ch, input int bin, input logic [7:0] exp_bcd,
                               input logic exp_err, input int exp_conv);
        int n;
        wait_idle();
        bin_in[8*ch +: 8] = 8'(bin);
        req = 3'(1 << ch);
        tick();
        check("one_ack", 32'(ack), 1 << ch);
        check("one_conv_bin", 32'(conv_bin), exp_conv);
        check("one_range_err", 32'(range_err[ch]), 32'(exp_err));
        req    = '0;
        bin_in = 24'($urandom);
        n = 1;
        while (bcd_done == '0 && n < 20) begin
            tick();
            n++;
        end
        mdl_bcd[ch] = exp_bcd;
        check("one_done_latency", n, LAT + 2);
        check("one_bcd_done", 32'(bcd_done), 1 << ch);
        check("one_bcd_out", 32'(bcd_out), 32'(mdl_pack()));
        check("one_conv_hold", 32'(conv_bin), exp_conv);
    endtask

    typedef struct {
        int         ch;
        int         bin;
        logic [7:0] bcd;
        logic       err;
        int         conv;
    } vec_t;

    vec_t tbl [9];
    int   order [$];
    int   when [$];
    int   c, ch1_acks;
    int   idle_at, ack_at, done_at, pg, ptr, g, v;
    logic found, perr;
    logic [7:0] pval, pbcd, e_conv;
    logic [NCH-1:0] e_rerr;

    initial begin
        tbl[0] = '{ch: 0, bin: 45,  bcd: 8'h45, err: 1'b0, conv: 45};
        tbl[1] = '{ch: 1, bin: 0,   bcd: 8'h00, err: 1'b0, conv: 0};
        tbl[2] = '{ch: 2, bin: 120, bcd: 8'h99, err: 1'b1, conv: 99};
        tbl[3] = '{ch: 2, bin: 7,   bcd: 8'h07, err: 1'b0, conv: 7};
        tbl[4] = '{ch: 1, bin: 99,  bcd: 8'h99, err: 1'b0, conv: 99};
        tbl[5] = '{ch: 0, bin: 100, bcd: 8'h99, err: 1'b1, conv: 99};
        tbl[6] = '{ch: 1, bin: 255, bcd: 8'h99, err: 1'b1, conv: 99};
        tbl[7] = '{ch: 0, bin: 9,   bcd: 8'h09, err: 1'b0, conv: 9};
        tbl[8] = '{ch: 1, bin: 86,  bcd: 8'h86, err: 1'b0, conv: 86};

        // Reset with no requests: everything quiet.
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            check("reset_quiet", {busy, ack, bcd_done, range_err, conv_bin}, 0);
            check("reset_bcd_out", 32'(bcd_out), 0);
            tick();
        end

        // Single ch0 conversion with exact latencies.
        convert_one(0, 45, 8'h45, 1'b0, 45);

        // All three at once: acks 0,1,2 spaced LAT+2 apart.
        do_reset(2);
        bin_in = {8'd23, 8'd59, 8'd59};
        req    = 3'b111;
        c      = 0;
        while (order.size() < 3 && c < 40) begin
            tick();
            c++;
            if (ack != '0) begin
                for (int k = 0; k < NCH; k++) begin
                    if (ack[k]) begin
                        order.push_back(k);
                        when.push_back(c);
                    end
                end
                req = req & ~ack;
            end
        end
        while (order.size() < 3) begin
            order.push_back(-1);
            when.push_back(-100);
        end
        check("all3_order0", order[0], 0);
        check("all3_order1", order[1], 1);
        check("all3_order2", order[2], 2);
        check("all3_gap01", when[1] - when[0], LAT + 2);
        check("all3_gap12", when[2] - when[1], LAT + 2);
        wait_idle();
        check("all3_bcd_out", 32'(bcd_out), 32'h235959);

        // ch0 and ch2 held continuously: grants alternate, ch1 untouched.
        order.delete();
        bin_in   = {8'd12, 8'd34, 8'd56};
        req      = 3'b101;
        c        = 0;
        ch1_acks = 0;
        while (order.size() < 4 && c < 60) begin
            tick();
            c++;
            if (ack[1]) ch1_acks++;
            for (int k = 0; k < NCH; k++) if (ack[k]) order.push_back(k);
        end
        req = '0;
        while (order.size() < 4) order.push_back(-1);
        check("alt_g0", order[0], 0);
        check("alt_g1", order[1], 2);
        check("alt_g2", order[2], 0);
        check("alt_g3", order[3], 2);
        check("alt_ch1_acks", ch1_acks, 0);
        wait_idle();

        // Reset while ch1 is waiting on the converter.
        do_reset(2);
        bin_in[15:8] = 8'd30;
        req          = 3'b010;
        tick();
        check("rst_mid_ack", 32'(ack), 3'b010);
        req = '0;
        tick();
        check("rst_mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("rst_mid_no_done", 32'(bcd_done), 0);
            check("rst_mid_bcd_out", 32'(bcd_out), 0);
            check("rst_mid_busy0", 32'(busy), 0);
            tick();
        end
        convert_one(1, 30, 8'h30, 1'b0, 30);

        for (int i = 0; i < 9; i++) begin
            convert_one(tbl[i].ch, tbl[i].bin, tbl[i].bcd, tbl[i].err, tbl[i].conv);
        end

        // Randomized run against a transaction-level model.
        do_reset(2);
        idle_at = 0;
        ack_at  = -1;
        done_at = -1;
        pg      = 0;
        ptr     = 0;
        e_conv  = '0;
        e_rerr  = '0;
        pval    = '0;
        pbcd    = '0;
        perr    = 1'b0;
        for (int cur = 0; cur < 600; cur++) begin
            if (cur == ack_at) begin
                e_conv     = pval;
                e_rerr[pg] = perr;
            end
            if (cur == done_at) mdl_bcd[pg] = pbcd;
            check("rnd_ack", 32'(ack), (cur == ack_at) ? (1 << pg) : 0);
            check("rnd_done", 32'(bcd_done), (cur == done_at) ? (1 << pg) : 0);
            check("rnd_bcd_out", 32'(bcd_out), 32'(mdl_pack()));
            check("rnd_range_err", 32'(range_err), 32'(e_rerr));
            check("rnd_conv_bin", 32'(conv_bin), 32'(e_conv));
            check("rnd_busy", 32'(busy), (cur < idle_at) ? 1 : 0);

            req = ($urandom_range(0, 3) == 0) ? '0 : 3'($urandom_range(1, 7));
            for (int k = 0; k < NCH; k++) bin_in[8*k +: 8] = 8'($urandom_range(0, 140));
            if (cur >= idle_at && req != '0) begin
                found = 1'b0;
                g     = 0;
                for (int i = 0; i < NCH; i++) begin
                    if (!found && req[(ptr + i) % NCH]) begin
                        found = 1'b1;
                        g     = (ptr + i) % NCH;
                    end
                end
                ptr     = (g + 1) % NCH;
                v       = int'(bin_in[8*g +: 8]);
                perr    = (v > 99);
                pval    = perr ? 8'd99 : 8'(v);
                pbcd    = bcd_of(int'(pval));
                pg      = g;
                ack_at  = cur + 1;
                done_at = cur + LAT + 2;
                idle_at = cur + LAT + 2;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
